pipelined_add_sub: RTL

//  Parametrised, pipelined two's-complement adder/subtractor for the CPU-System ALU path.

---
 rtl/pipelined_add_sub_if.sv | 28 ++
 rtl/pipelined_add_sub.sv | 116 +++++++++++
 2 files changed

// File: rtl/pipelined_add_sub_if.sv
// Operand/result stream bundle for pipelined_add_sub.
// master drives operands and consumes results, slave is the adder.
interface pipelined_add_sub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, op_sub, a, b, c_in, out_ready,
    input  in_ready, out_valid, result, c_out, ovf, zero
  );

  modport slave (
    input  in_valid, op_sub, a, b, c_in, out_ready,
    output in_ready, out_valid, result, c_out, ovf, zero
  );
endinterface

// File: rtl/pipelined_add_sub.sv
// Segmented ripple-carry add/sub: STAGES slices of WIDTH/STAGES bits, registered carry between slices.
// Define ADD_SUB_SAT_EN to saturate the result on signed overflow (default: wrap).
module pipelined_add_sub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input logic                 clk,
  input logic                 clr,
  pipelined_add_sub_if.slave  bus
);
  localparam int SEG = WIDTH / STAGES;

  logic             out_valid_reg;
  logic [WIDTH-1:0] result_reg;
  logic             c_out_reg;
  logic             ovf_reg;
  logic             zero_reg;
  logic             adv;

  // The whole pipe moves as one; bubbles are not squeezed out.
  assign adv          = ~out_valid_reg | bus.out_ready;
  assign bus.in_ready = adv;

  assign bus.out_valid = out_valid_reg;
  assign bus.result    = result_reg;
  assign bus.c_out     = c_out_reg;
  assign bus.ovf       = ovf_reg;
  assign bus.zero      = zero_reg;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : stage_g
      // Operands still to be added occupy [HI_W-1:0]; the current slice is the bottom SEG bits.
      localparam int LO   = gi * SEG;
      localparam int HI_W = WIDTH - LO;

      logic              valid_in;
      logic              cin;
      logic [HI_W-1:0]   a_in;
      logic [HI_W-1:0]   bx_in;
      logic [SEG:0]      seg_sum;
      logic [LO+SEG-1:0] sum_next;

      if (gi == 0) begin : head_g
        assign valid_in = bus.in_valid;
        assign a_in     = bus.a;
        assign bx_in    = bus.op_sub ? ~bus.b : bus.b;
        assign cin      = bus.op_sub | bus.c_in;
        assign sum_next = seg_sum[SEG-1:0];
      end else begin : body_g
        assign valid_in = stage_g[gi-1].reg_g.valid_reg;
        assign a_in     = stage_g[gi-1].reg_g.a_reg;
        assign bx_in    = stage_g[gi-1].reg_g.bx_reg;
        assign cin      = stage_g[gi-1].reg_g.carry_reg;
        assign sum_next = {seg_sum[SEG-1:0], stage_g[gi-1].reg_g.sum_reg};
      end

      assign seg_sum = {1'b0, a_in[SEG-1:0]} + {1'b0, bx_in[SEG-1:0]} + {{SEG{1'b0}}, cin};

      if (gi < STAGES - 1) begin : reg_g
        logic                 valid_reg;
        logic                 carry_reg;
        logic [HI_W-SEG-1:0]  a_reg;
        logic [HI_W-SEG-1:0]  bx_reg;
        logic [LO+SEG-1:0]    sum_reg;

        always_ff @(posedge clk) begin
          if (clr) begin
            valid_reg <= 1'b0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            bx_reg    <= '0;
            sum_reg   <= '0;
          end else if (adv) begin
            valid_reg <= valid_in;
            carry_reg <= seg_sum[SEG];
            a_reg     <= a_in[HI_W-1:SEG];
            bx_reg    <= bx_in[HI_W-1:SEG];
            sum_reg   <= sum_next;
          end
        end
      end else begin : tail_g
        logic             raw_ovf;
        logic [WIDTH-1:0] res_next;

        // Both addend signs live in the top slice, so overflow needs only this stage.
        assign raw_ovf = (a_in[SEG-1] == bx_in[SEG-1]) && (seg_sum[SEG-1] != a_in[SEG-1]);

`ifdef ADD_SUB_SAT_EN
        localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
        localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
        // On overflow the true sign is the shared operand sign.
        assign res_next = raw_ovf ? (a_in[SEG-1] ? SMIN : SMAX) : sum_next;
`else
        assign res_next = sum_next;
`endif

        always_ff @(posedge clk) begin
          if (clr) begin
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            c_out_reg     <= 1'b0;
            ovf_reg       <= 1'b0;
            zero_reg      <= 1'b0;
          end else if (adv) begin
            out_valid_reg <= valid_in;
            result_reg    <= res_next;
            c_out_reg     <= seg_sum[SEG];
            ovf_reg       <= raw_ovf;
            zero_reg      <= (res_next == '0);
          end
        end
      end
    end
  endgenerate
endmodule
